// File: rtl/br_cmp_search.sv
// Bit-serial search for a hidden target value via an external lt/eq/gt comparator.
// Optional per-probe response timeout is built when BR_CMP_SEARCH_TIMEOUT_EN is defined.
module br_cmp_search #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [WIDTH-1:0]             probe,
  output logic                         probe_valid,
  input  logic                         cmp_valid,
  input  logic                         lt,
  input  logic                         eq,
  input  logic                         gt,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic                         err,
  output logic [WIDTH-1:0]             result,
  output logic [$clog2(WIDTH+2)-1:0]   steps
);

  typedef enum logic [1:0] {IDLE, PROBE, CHECK, FINISH} state_t;

  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if (WIDTH < 2 || WIDTH > 16 || TIMEOUT < 1) begin : g_bad_param
      $error("br_cmp_search: illegal WIDTH or TIMEOUT");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mask;   // one-hot bit currently under test
  logic [WIDTH-1:0] acc_n;
  logic             accept;
  logic             resp_ok;
  logic             timeout_hit;

  assign accept  = probe_valid & cmp_valid;
  // exactly one flag: odd parity but not all three
  assign resp_ok = (lt ^ eq ^ gt) & ~(lt & eq & gt);
  assign acc_n   = lt ? (acc | mask) : acc;

`ifdef BR_CMP_SEARCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  assign timeout_hit = probe_valid & ~cmp_valid & (wait_cnt == TW'(TIMEOUT - 1));

  // Acceptance always presents a new probe (or ends the search), so it clears the count.
  always_ff @(posedge clk) begin
    if (rst || !probe_valid || accept) wait_cnt <= '0;
    else                               wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      mask        <= '0;
      probe       <= '0;
      probe_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      steps       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= PROBE;
            busy        <= 1'b1;
            found       <= 1'b0;
            err         <= 1'b0;
            steps       <= '0;
            acc         <= '0;
            mask        <= MSB_MASK;
            probe       <= MSB_MASK;
            probe_valid <= 1'b1;
          end
        end
        PROBE, CHECK: begin
          if (accept) begin
            steps <= steps + 1'b1;
            if (!resp_ok) begin
              err         <= 1'b1;
              found       <= 1'b0;
              result      <= acc;
              state       <= FINISH;
              probe_valid <= 1'b0;
              done        <= 1'b1;
            end else if (state == CHECK) begin
              found       <= eq;
              result      <= acc;
              state       <= FINISH;
              probe_valid <= 1'b0;
              done        <= 1'b1;
            end else if (eq) begin
              found       <= 1'b1;
              result      <= probe;
              state       <= FINISH;
              probe_valid <= 1'b0;
              done        <= 1'b1;
            end else if (mask[0]) begin
              // all bits resolved without a hit: confirm the accumulator itself
              acc   <= acc_n;
              probe <= acc_n;
              state <= CHECK;
            end else begin
              acc   <= acc_n;
              mask  <= mask >> 1;
              probe <= acc_n | (mask >> 1);
            end
          end else if (timeout_hit) begin
            err         <= 1'b1;
            found       <= 1'b0;
            result      <= acc;
            state       <= FINISH;
            probe_valid <= 1'b0;
            done        <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
